ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS-style pipeline.
- Sits directly upstream of the ALU: registers decoded instructions and drives the ALU's iA, iB and iF.
- Drives control bits downstream to EX/MEM.
- Detects load-use hazards and inserts bubbles; accepts branch flushes.

Parameters:
- DATA_W, 32, datapath width (ALU operands, immediates, forwarded results).
- REG_AW, 5, register-number width.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iReset  input  1  synchronous, active-high reset.
- iIdRsVal  input  DATA_W  register-file rs read value from ID.
- iIdRtVal  input  DATA_W  register-file rt read value from ID.
- iIdImm  input  DATA_W  sign-extended immediate from ID.
- iIdRs, iIdRt, iIdRd  input  REG_AW each  source and destination register numbers.
- iIdValid  input  1  ID holds a real instruction.
- iIdAluCtl  input  3  ALU function code, same encoding as ALU iF.
- iIdAluSrc  input  1  1 selects immediate as B operand.
- iIdRegDst  input  1  1 selects rd as write register, 0 selects rt.
- iIdRegWrite, iIdMemRead, iIdMemWrite, iIdMemToReg, iIdBranch  input  1 each  control bits.
- iFlush  input  1  branch taken in EX; discard ID instruction.
- iExMemRegWrite  input  1  EX/MEM stage will write a register.
- iExMemWriteReg  input  REG_AW  EX/MEM destination register.
- iExMemResult  input  DATA_W  EX/MEM ALU result.
- iMemWbRegWrite  input  1  MEM/WB stage will write a register.
- iMemWbWriteReg  input  REG_AW  MEM/WB destination register.
- iMemWbResult  input  DATA_W  MEM/WB writeback value.
- oA  output  DATA_W  ALU operand A.
- oB  output  DATA_W  ALU operand B.
- oF  output  3  ALU function.
- oStoreData  output  DATA_W  forwarded rt value for stores.
- oWriteReg  output  REG_AW  destination register.
- oValid  output  1  stage holds a real instruction.
- oRegWrite, oMemRead, oMemWrite, oMemToReg, oBranch  output  1 each  registered control bits.
- oStall  output  1  load-use stall request to PC and IF/ID.

Behaviour:
- Registered state: rsVal, rtVal, imm, rs, rt, rd, aluCtl, aluSrc, regDst, regWrite, memRead, memWrite, memToReg, branch, valid.
- Update priority at each rising edge of iClk:
  1. iReset: every field is 0.
  2. iFlush or load-use hazard: load a bubble. All fields are 0, including valid and every control bit.
  3. Otherwise: capture the ID inputs, with valid = iIdValid.
- Bubble and reset outputs: oF=000, oRegWrite=oMemRead=oMemWrite=oMemToReg=oBranch=0, oValid=0, oWriteReg=0. oA, oB and oStoreData follow forwarding of zeroed fields; downstream must ignore them.
- Load-use hazard (combinational):
  - Hazard = valid & memRead & (rt != 0) & (rt == iIdRs | rt == iIdRt).
  - The rt comparison is conservative; it ignores whether ID actually uses rt.
- oStall = hazard & ~iFlush. Upstream holds PC and IF/ID while oStall=1. This stage inserts exactly one bubble; the next cycle's comparison is against the bubble, so oStall deasserts.
- Flush and hazard in the same cycle: bubble is loaded, oStall=0.
- Forwarding for operand A (combinational, from registered rs), priority high to low:
  1. iExMemRegWrite & iExMemWriteReg != 0 & iExMemWriteReg == rs: iExMemResult.
  2. iMemWbRegWrite & iMemWbWriteReg != 0 & iMemWbWriteReg == rs: iMemWbResult.
  3. Otherwise: rsVal.
- Forwarding for rt uses the same priority rules with rt and rtVal; the result is fwdB.
- Register 0 is never forwarded.
- oStoreData = fwdB.
- oB = aluSrc ? imm : fwdB.
- oA = forwarded rs value.
- oWriteReg = regDst ? rd : rt.
- Latency: ID inputs appear on the outputs 1 cycle after the capturing edge. Forwarding paths have zero-cycle latency.
- Reset asserted mid-stream clears the stage on that edge and overrides iFlush and the hazard. oStall is 0 in the cycle after reset.

Test Plan:
- Reset: assert iReset for 2 cycles with arbitrary ID inputs -> oValid=0, oRegWrite=0, oMemRead=0, oF=000, oStall=0.
- Plain capture: rs=1, rsVal=7, rt=2, rtVal=5, AluCtl=010, AluSrc=0, RegDst=1, rd=3, no forwarding hits -> next cycle oA=7, oB=5, oF=010, oWriteReg=3, oValid=1.
- Forwarding priority:
  - stage rs=4; EX/MEM writes r4=0x11; MEM/WB writes r4=0x22 -> oA=0x11.
  - Drop EX/MEM RegWrite -> oA=0x22.
  - Set write register to r0 on both -> oA=rsVal.
- Immediate/store: AluSrc=1, imm=0xFFFFFFFC, rt forwarded from MEM/WB as 0x99 -> oB=0xFFFFFFFC, oStoreData=0x99.
- Load-use: stage holds lw with rt=8; ID has rs=8 -> oStall=1 this cycle. Next cycle oValid=0, oRegWrite=0, oStall=0.
- Flush with hazard: same setup as load-use plus iFlush=1 -> oStall=0; next cycle bubble (oValid=0, oMemWrite=0, oBranch=0).

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Drives ALU operands/function and the registered control bits toward EX/MEM.
module ex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic [DATA_W-1:0] iIdRsVal,
   input  logic [DATA_W-1:0] iIdRtVal,
   input  logic [DATA_W-1:0] iIdImm,
   input  logic [REG_AW-1:0] iIdRs,
   input  logic [REG_AW-1:0] iIdRt,
   input  logic [REG_AW-1:0] iIdRd,
   input  logic              iIdValid,
   input  logic [2:0]        iIdAluCtl,
   input  logic              iIdAluSrc,
   input  logic              iIdRegDst,
   input  logic              iIdRegWrite,
   input  logic              iIdMemRead,
   input  logic              iIdMemWrite,
   input  logic              iIdMemToReg,
   input  logic              iIdBranch,
   input  logic              iFlush,
   input  logic              iExMemRegWrite,
   input  logic [REG_AW-1:0] iExMemWriteReg,
   input  logic [DATA_W-1:0] iExMemResult,
   input  logic              iMemWbRegWrite,
   input  logic [REG_AW-1:0] iMemWbWriteReg,
   input  logic [DATA_W-1:0] iMemWbResult,
   output logic [DATA_W-1:0] oA,
   output logic [DATA_W-1:0] oB,
   output logic [2:0]        oF,
   output logic [DATA_W-1:0] oStoreData,
   output logic [REG_AW-1:0] oWriteReg,
   output logic              oValid,
   output logic              oRegWrite,
   output logic              oMemRead,
   output logic              oMemWrite,
   output logic              oMemToReg,
   output logic              oBranch,
   output logic              oStall
);

   logic [DATA_W-1:0] rs_val_reg, rt_val_reg, imm_reg;
   logic [REG_AW-1:0] rs_reg, rt_reg, rd_reg;
   logic [2:0]        alu_ctl_reg;
   logic              alu_src_reg, reg_dst_reg, reg_write_reg, mem_read_reg;
   logic              mem_write_reg, mem_to_reg_reg, branch_reg, valid_reg;

   logic hazard;
   logic bubble;

   // Conservative: any ID source matching the load's rt stalls, used or not.
   assign hazard = valid_reg & mem_read_reg & (rt_reg != '0) &
                   ((rt_reg == iIdRs) | (rt_reg == iIdRt));
   assign bubble = iFlush | hazard;
   assign oStall = hazard & ~iFlush;

   always_ff @(posedge iClk) begin
      if (iReset || bubble) begin
         rs_val_reg     <= '0;
         rt_val_reg     <= '0;
         imm_reg        <= '0;
         rs_reg         <= '0;
         rt_reg         <= '0;
         rd_reg         <= '0;
         alu_ctl_reg    <= '0;
         alu_src_reg    <= 1'b0;
         reg_dst_reg    <= 1'b0;
         reg_write_reg  <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         mem_to_reg_reg <= 1'b0;
         branch_reg     <= 1'b0;
         valid_reg      <= 1'b0;
      end else begin
         rs_val_reg     <= iIdRsVal;
         rt_val_reg     <= iIdRtVal;
         imm_reg        <= iIdImm;
         rs_reg         <= iIdRs;
         rt_reg         <= iIdRt;
         rd_reg         <= iIdRd;
         alu_ctl_reg    <= iIdAluCtl;
         alu_src_reg    <= iIdAluSrc;
         reg_dst_reg    <= iIdRegDst;
         reg_write_reg  <= iIdRegWrite;
         mem_read_reg   <= iIdMemRead;
         mem_write_reg  <= iIdMemWrite;
         mem_to_reg_reg <= iIdMemToReg;
         branch_reg     <= iIdBranch;
         valid_reg      <= iIdValid;
      end
   end

   // Operand 0 is rs, operand 1 is rt; EX/MEM wins over MEM/WB, r0 never forwards.
   logic [1:0][REG_AW-1:0] src_num;
   logic [1:0][DATA_W-1:0] src_val;
   logic [1:0][DATA_W-1:0] fwd_val;

   assign src_num[0] = rs_reg;
   assign src_num[1] = rt_reg;
   assign src_val[0] = rs_val_reg;
   assign src_val[1] = rt_val_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic hit_ex_mem;
      logic hit_mem_wb;
      assign hit_ex_mem = iExMemRegWrite & (iExMemWriteReg != '0) & (iExMemWriteReg == src_num[gi]);
      assign hit_mem_wb = iMemWbRegWrite & (iMemWbWriteReg != '0) & (iMemWbWriteReg == src_num[gi]);
      assign fwd_val[gi] = hit_ex_mem ? iExMemResult :
                           hit_mem_wb ? iMemWbResult : src_val[gi];
   end

   assign oA         = fwd_val[0];
   assign oStoreData = fwd_val[1];
   assign oB         = alu_src_reg ? imm_reg : fwd_val[1];
   assign oF         = alu_ctl_reg;
   assign oWriteReg  = reg_dst_reg ? rd_reg : rt_reg;
   assign oValid     = valid_reg;
   assign oRegWrite  = reg_write_reg;
   assign oMemRead   = mem_read_reg;
   assign oMemWrite  = mem_write_reg;
   assign oMemToReg  = mem_to_reg_reg;
   assign oBranch    = branch_reg;

endmodule
